pico_sample_buffer: RTL and testbench

Downstream stage of the PicoBlaze speech core. Drives the `start_pico` / `pico_done` handshake to pull one 8-bit sample per request from the processor's `output_data` port. Buffers the samples in a small FIFO and releases them to the audio path at a fixed sample rate. Absorbs the processor's variable per-sample latency so the audio output stays jitter-free.

---
 rtl/pico_sample_buffer.sv | 138 +++++++++++++
 tb/tb_pico_sample_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pico_sample_buffer
// Description : Pulls samples from the PicoBlaze over a start/done handshake,
//               buffers them in a FIFO and plays them out at a fixed rate.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_sample_buffer #(
    parameter int CLK_FREQ_IN_HZ    = 50_000_000,
    parameter int SAMPLE_RATE_IN_HZ = 22_000,
    parameter int FIFO_DEPTH_LOG2   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               pico_data,
    input  logic                     pico_done,
    input  logic                     clear_underrun,
    output logic                     start_pico,
    output logic [7:0]               audio_out,
    output logic                     audio_valid,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     underrun
);

    localparam int c_div   = CLK_FREQ_IN_HZ / SAMPLE_RATE_IN_HZ;
    localparam int c_depth = 1 << FIFO_DEPTH_LOG2;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_req     = 2'd1;
    localparam logic [1:0] c_release = 2'd2;

    logic [1:0]                 r_state;
    logic                       r_start_pico;
    logic [7:0]                 r_audio_out;
    logic                       r_audio_valid;
    logic [FIFO_DEPTH_LOG2:0]   r_level;
    logic                       r_underrun;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [7:0]                 r_mem [c_depth];

    logic w_push;
    logic w_tick;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Level can only reach D, so its MSB alone flags a full FIFO.
    assign w_full  = r_level[FIFO_DEPTH_LOG2];
    assign w_empty = (r_level == '0);
    assign w_push  = (r_state == c_req) && pico_done;
    assign w_tick  = enable && (r_cnt == c_cnt_max);
    assign w_pop   = w_tick && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pico_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_start_pico  <= 1'b0;
            r_audio_out   <= 8'h80;
            r_audio_valid <= 1'b0;
            r_level       <= '0;
            r_underrun    <= 1'b0;
            r_cnt         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (enable && !w_full) begin
                        r_state      <= c_req;
                        r_start_pico <= 1'b1;
                    end
                end
                c_req: begin
                    if (pico_done) begin
                        r_state      <= c_release;
                        r_start_pico <= 1'b0;
                    end
                end
                c_release: begin
                    if (!pico_done) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state      <= c_idle;
                    r_start_pico <= 1'b0;
                end
            endcase

            if (!enable || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
                r_audio_out <= r_mem[r_rd_ptr];
            end
            r_audio_valid <= w_pop;

            if (w_push && !w_pop) begin
                r_level <= r_level + (FIFO_DEPTH_LOG2 + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (FIFO_DEPTH_LOG2 + 1)'(1);
            end

            // An empty tick in the same cycle as a clear keeps the flag set.
            if (w_tick && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign start_pico  = r_start_pico;
    assign audio_out   = r_audio_out;
    assign audio_valid = r_audio_valid;
    assign fifo_level  = r_level;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pico_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pico_sample_buffer
// Description : Directed vector bench: a fast instance (N=4) driven from a
//               cycle table plus wrap sequence, and a default instance fed by
//               a processor model for the fill-to-full scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_sample_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: N = 88000 / 22000 = 4, D = 16
    logic       a_rst, a_en, a_done, a_clr;
    logic [7:0] a_data;
    logic       a_start, a_valid, a_und;
    logic [7:0] a_aout;
    logic [4:0] a_lvl;

    pico_sample_buffer #(
        .CLK_FREQ_IN_HZ   (88_000),
        .SAMPLE_RATE_IN_HZ(22_000),
        .FIFO_DEPTH_LOG2  (4)
    ) dut_a (
        .clk           (clk),
        .reset         (a_rst),
        .enable        (a_en),
        .pico_data     (a_data),
        .pico_done     (a_done),
        .clear_underrun(a_clr),
        .start_pico    (a_start),
        .audio_out     (a_aout),
        .audio_valid   (a_valid),
        .fifo_level    (a_lvl),
        .underrun      (a_und)
    );

    // Instance B: default parameters, N = 2272, D = 16
    logic       b_rst, b_en, b_clr;
    logic       b_done = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_start, b_valid, b_und;
    logic [7:0] b_aout;
    logic [4:0] b_lvl;

    pico_sample_buffer dut_b (
        .clk           (clk),
        .reset         (b_rst),
        .enable        (b_en),
        .pico_data     (b_data),
        .pico_done     (b_done),
        .clear_underrun(b_clr),
        .start_pico    (b_start),
        .audio_out     (b_aout),
        .audio_valid   (b_valid),
        .fifo_level    (b_lvl),
        .underrun      (b_und)
    );

    // Processor model for B: answers 5 cycles after start_pico, data 0x10, 0x11, ...
    int         b_lat_cnt = 0;
    logic [7:0] b_next    = 8'h10;
    always @(negedge clk) begin
        if (b_rst) begin
            b_done    = 1'b0;
            b_lat_cnt = 0;
        end else if (b_done && !b_start) begin
            b_done = 1'b0;
        end else if (b_start && !b_done) begin
            b_lat_cnt = b_lat_cnt + 1;
            if (b_lat_cnt >= 5) begin
                b_done    = 1'b1;
                b_data    = b_next;
                b_next    = b_next + 8'h01;
                b_lat_cnt = 0;
            end
        end
    end

    typedef struct {
        logic       rst, en, done;
        logic [7:0] data;
        logic       clr;
        logic       s;
        logic [7:0] ao;
        logic       v;
        logic [4:0] l;
        logic       u;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic done,
                                input logic [7:0] data, input logic clr,
                                input logic s, input logic [7:0] ao, input logic v,
                                input logic [4:0] l, input logic u);
        vec_t r;
        r.rst = rst; r.en = en; r.done = done; r.data = data; r.clr = clr;
        r.s = s; r.ao = ao; r.v = v; r.l = l; r.u = u;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic a_cycle(input logic rst, input logic en, input logic done,
                           input logic [7:0] data, input logic clr);
        @(negedge clk);
        a_rst = rst; a_en = en; a_done = done; a_data = data; a_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic a_prefill(input logic [7:0] data, input logic [4:0] exp_lvl);
        a_cycle(0, 1, 0, 8'h00, 0);
        check("prefill start_pico", a_start, 1);
        a_cycle(0, 0, 1, data, 0);
        check("prefill level", a_lvl, exp_lvl);
        check("prefill release", a_start, 0);
        a_cycle(0, 0, 0, 8'h00, 0);
    endtask

    int         b_cyc;
    int         t1;
    logic       bad;

    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_done = 1'b0; a_data = 8'h00; a_clr = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0;

        // rst en done data clr | start aout valid level underrun
        vq.push_back(mk(1,0,0,8'h00,0, 0,8'h80,0,0,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,0,0));
        // prefill 0x10 with enable dropped while in REQ
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,0,0));
        vq.push_back(mk(0,0,0,8'h00,0, 1,8'h80,0,0,0));
        vq.push_back(mk(0,0,1,8'h10,0, 0,8'h80,0,1,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,1,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,1,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,1,0));
        vq.push_back(mk(0,0,1,8'h11,0, 0,8'h80,0,2,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,2,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,2,0));
        vq.push_back(mk(0,0,1,8'h12,0, 0,8'h80,0,3,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,3,0));
        // playback: first tick on the 4th enabled edge, aligned with a capture at level 3
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h80,0,3,0));
        vq.push_back(mk(0,1,1,8'h13,0, 0,8'h10,1,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 0,8'h10,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h10,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h10,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h11,1,2,0));
        vq.push_back(mk(0,1,1,8'h14,0, 0,8'h11,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 0,8'h11,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h11,0,3,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h12,1,2,0));
        // processor stalls: drain 0x13, 0x14 then underrun
        for (int i = 0; i < 3; i++) vq.push_back(mk(0,1,0,8'h00,0, 1,8'h12,0,2,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h13,1,1,0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0,1,0,8'h00,0, 1,8'h13,0,1,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h14,1,0,0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0,1,0,8'h00,0, 1,8'h14,0,0,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h14,0,0,1));
        vq.push_back(mk(0,1,0,8'h00,1, 1,8'h14,0,0,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h14,0,0,0));
        vq.push_back(mk(0,1,0,8'h00,0, 1,8'h14,0,0,0));
        vq.push_back(mk(0,1,0,8'h00,1, 1,8'h14,0,0,1));
        // reset mid-handshake, then a lingering pico_done is ignored
        vq.push_back(mk(1,1,1,8'h55,0, 0,8'h80,0,0,0));
        vq.push_back(mk(0,0,1,8'h55,0, 0,8'h80,0,0,0));
        vq.push_back(mk(0,0,0,8'h00,0, 0,8'h80,0,0,0));

        foreach (vq[i]) begin
            a_cycle(vq[i].rst, vq[i].en, vq[i].done, vq[i].data, vq[i].clr);
            check($sformatf("row%0d start_pico", i), a_start, vq[i].s);
            check($sformatf("row%0d audio_out", i), a_aout, vq[i].ao);
            check($sformatf("row%0d audio_valid", i), a_valid, vq[i].v);
            check($sformatf("row%0d fifo_level", i), a_lvl, vq[i].l);
            check($sformatf("row%0d underrun", i), a_und, vq[i].u);
        end

        // Pointer wrap: fill 15, aligned push/pop at 15, fill to 16, drain all
        for (int i = 0; i < 15; i++) a_prefill(8'h20 + 8'(i), 5'(i + 1));
        for (int j = 0; j < 3; j++) a_cycle(0, 1, 0, 8'h00, 0);
        a_cycle(0, 1, 1, 8'h2F, 0);
        check("aligned15 level", a_lvl, 15);
        check("aligned15 audio_out", a_aout, 8'h20);
        check("aligned15 audio_valid", a_valid, 1);
        a_cycle(0, 0, 0, 8'h00, 0);
        a_prefill(8'h30, 5'd16);
        for (int j = 0; j < 3; j++) begin
            a_cycle(0, 1, 0, 8'h00, 0);
            check("full no request", a_start, 0);
            check("full level", a_lvl, 16);
        end
        a_cycle(0, 1, 0, 8'h00, 0);
        check("pop from full audio_out", a_aout, 8'h21);
        check("pop from full level", a_lvl, 15);
        check("pop from full start_pico", a_start, 0);
        for (int k = 0; k < 15; k++) begin
            for (int j = 0; j < 3; j++) begin
                a_cycle(0, 1, 0, 8'h00, 0);
                check("drain gap audio_valid", a_valid, 0);
            end
            a_cycle(0, 1, 0, 8'h00, 0);
            check($sformatf("drain%0d audio_valid", k), a_valid, 1);
            check($sformatf("drain%0d audio_out", k), a_aout, 8'h22 + 8'(k));
            check($sformatf("drain%0d level", k), a_lvl, 5'(14 - k));
        end
        for (int j = 0; j < 4; j++) a_cycle(0, 1, 0, 8'h00, 0);
        check("wrap underrun", a_und, 1);
        check("wrap underrun audio_out hold", a_aout, 8'h30);
        check("wrap underrun audio_valid", a_valid, 0);

        // Instance B: fill to full with processor model, then slow playback
        @(negedge clk); b_rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("b reset start_pico", b_start, 0);
        check("b reset audio_out", b_aout, 8'h80);
        check("b reset level", b_lvl, 0);
        @(negedge clk); b_rst = 1'b0; b_en = 1'b1;
        @(posedge clk); #1;
        b_cyc = 1;
        check("b start one cycle after enable", b_start, 1);
        for (int k = 0; k < 400 && b_lvl != 5'd16; k++) begin
            @(posedge clk); #1; b_cyc++;
        end
        check("b fill level", b_lvl, 16);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; b_cyc++;
            if (b_start) bad = 1'b1;
        end
        check("b full no request", bad, 0);
        for (int k = 0; k < 3000 && !b_valid; k++) begin
            @(posedge clk); #1; b_cyc++;
        end
        check("b first tick cycle", b_cyc, 2272);
        check("b first sample", b_aout, 8'h10);
        check("b level after pop", b_lvl, 15);
        t1 = b_cyc;
        @(posedge clk); #1; b_cyc++;
        for (int k = 0; k < 3000 && !b_valid; k++) begin
            @(posedge clk); #1; b_cyc++;
        end
        check("b tick period", b_cyc - t1, 2272);
        check("b second sample", b_aout, 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
